// File: rtl/result_sel_arbiter_pkg.sv
// Shared types and constants for the result selector arbiter (package rsa_pkg).
// Build option FIXED_PRIO_EN selects fixed-priority picking instead of round-robin.
package rsa_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 4;
  localparam int IDX_W      = 3;

  // Code that makes the selector output zero; never a requester index.
  localparam logic [SEL_W_DEF-1:0] IDLE_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/result_sel_arbiter_rr_pick.sv
// Combinational requester picker: round-robin from ptr_i, or lowest index when
// FIXED_PRIO_EN is defined.
module rr_pick
  import rsa_pkg::*;
#(
  parameter int N_REQ = 7
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_req_o
);

  logic [IDX_W-1:0] base;
  int               idx;

  always_comb begin
`ifdef FIXED_PRIO_EN
    base = '0;
`else
    base = ptr_i;
`endif
    grant_o = '0;
    idx     = 0;
    // Walk from farthest to nearest so the nearest asserted requester wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % N_REQ;
      if (req_i[idx]) grant_o = IDX_W'(idx);
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/result_sel_arbiter.sv
// Arbiter/sequencer for the shared 7-input result selector and output gate;
// FIXED_PRIO_EN switches the picker to fixed priority (no rr_ptr register).
module result_sel_arbiter
  import rsa_pkg::*;
#(
  parameter int N_REQ  = 7,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  ack,
  output logic [SEL_W-1:0]  sel,
  output logic              gate_en,
  input  logic [DATA_W-1:0] mux_y,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: out_data is offered while out_valid=1 and is consumed on the
  // rising edge where out_valid=1 and out_ready=1; out_ready is ignored otherwise.

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               gate_en_q, gate_en_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [IDX_W-1:0]   ptr;

`ifdef FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  assign ptr = rr_ptr_q;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i     (req),
    .ptr_i     (ptr),
    .grant_o   (pick),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = SEL_W'(IDLE_SEL);
    gate_en_d   = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ack_d       = '0;
`ifndef FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d   = pick;
          sel_d     = SEL_W'(pick);
          gate_en_d = 1'b1;
          state_d   = SEL;
        end
      end
      SEL: begin
        out_data_d  = mux_y;
        out_valid_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (out_ready) begin
          out_valid_d    = 1'b0;
          ack_d[grant_q] = 1'b1;
`ifndef FIXED_PRIO_EN
          rr_ptr_d = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= SEL_W'(IDLE_SEL);
      gate_en_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= '0;
`ifndef FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      gate_en_q   <= gate_en_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
`ifndef FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign gate_en   = gate_en_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ack       = ack_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_result_sel_arbiter.sv
// Directed plus randomized bench for result_sel_arbiter against a grant-order model.
module tb_result_sel_arbiter;

  localparam int N = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  ack;
  logic [3:0]    sel;
  logic          gate_en;
  logic [31:0]   mux_y = '0;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mptr  = 0;
  int ack_cyc = 0;
  logic [31:0] exp_q[$];

  result_sel_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .ack       (ack),
    .sel       (sel),
    .gate_en   (gate_en),
    .mux_y     (mux_y),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: first asserted requester scanning ptr, ptr+1, ... modulo N.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    int base;
    base = p;
`ifdef FIXED_PRIO_EN
    base = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    mux_y     = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mptr = 0;
    exp_q.delete();
  endtask

  // One complete transfer: waits for SEL, drives mux_y, holds off out_ready
  // for rdy_dly cycles, then accepts and checks the ack pulse.
  task automatic xfer(input logic [31:0] data, input int rdy_dly, input bit drop_own,
                      input bit drop_in_sel, input logic [N-1:0] pulse_bits,
                      input logic [N-1:0] add_bits);
    logic [N-1:0] prev;
    logic [31:0]  expd;
    logic [N-1:0] onehot;
    bit           seen;
    int           g;
    seen = 0;
    prev = req;
    for (int i = 0; i < 20 && !seen; i++) begin
      prev = req;
      @(negedge clk);
      if (gate_en === 1'b1) seen = 1;
    end
    chk("sel_reached", 32'(seen), 32'd1);
    if (!seen) return;
    g = model_pick(prev, mptr);
    chk("sel_code", 32'(sel), 32'(g));
    chk("sel_busy", 32'(busy), 32'd1);
    chk("sel_no_valid", 32'(out_valid), 32'd0);
    chk("sel_no_ack", 32'(ack), 32'd0);
    mux_y = data;
    exp_q.push_back(data);
    if (drop_in_sel) req = '0;
    @(negedge clk);
    mux_y = $urandom;
    expd = exp_q.pop_front();
    chk("wait_valid", 32'(out_valid), 32'd1);
    chk("wait_data", out_data, expd);
    chk("wait_sel_idle", 32'(sel), 32'hF);
    chk("wait_gate_off", 32'(gate_en), 32'd0);
    req = req | add_bits;
    for (int i = 0; i < rdy_dly; i++) begin
      if (i == 3) req = req ^ pulse_bits;
      if (i == 5) req = req ^ pulse_bits;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, expd);
      chk("bp_sel", {28'd0, sel, 1'b0, gate_en, 1'b0, busy} >> 4, {28'd0, 4'hF});
      chk("bp_no_ack", 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ack_cyc = cyc;
    onehot = '0;
    onehot[g] = 1'b1;
    chk("ack_pulse", 32'(ack), 32'(onehot));
    chk("ack_valid_clr", 32'(out_valid), 32'd0);
    chk("ack_idle", 32'(busy), 32'd0);
    if (drop_own) req[g] = 1'b0;
`ifndef FIXED_PRIO_EN
    mptr = (g + 1) % N;
`endif
  endtask

  initial begin
    int prev_ack;
    bit seen;

    // reset state
    do_reset();
    chk("rst_sel", 32'(sel), 32'hF);
    chk("rst_gate", 32'(gate_en), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // out_ready while idle is ignored
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rdy_valid", 32'(out_valid), 32'd0);
      chk("idle_rdy_ack", 32'(ack), 32'd0);
      chk("idle_rdy_busy", 32'(busy), 32'd0);
    end
    out_ready = 1'b0;

    // single request
    req = 7'b0000100;
    xfer(32'h12345678, 0, 1, 0, '0, '0);

    // fairness with all requesters held
    do_reset();
    req = '1;
    prev_ack = 0;
    for (int t = 0; t < 8; t++) begin
      xfer($urandom, 0, 0, 0, '0, '0);
      if (t == 7) req = '0;
      if (t > 0) chk("rr_period", 32'(ack_cyc - prev_ack), 32'd3);
      prev_ack = ack_cyc;
    end

    // wrap from pointer 6 back to 0
    do_reset();
    req = 7'b0100000;
    xfer(32'hA5A50005, 0, 1, 0, '0, '0);
    req = 7'b1000001;
    xfer(32'hA5A50006, 0, 1, 0, '0, '0);
    xfer(32'hA5A50000, 0, 1, 0, '0, '0);

    // backpressure with req[3] pulsed while waiting
    req = 7'b0001000;
    xfer(32'hCAFEF00D, 10, 1, 0, 7'b0001000, '0);
    req = '0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_single_ack", 32'(ack), 32'd0);
      chk("bp_stay_idle", 32'(busy), 32'd0);
    end

    // request withdrawn during SEL still completes
    req = 7'b0010000;
    xfer(32'h0BADC0DE, 1, 0, 1, '0, '0);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      if (req == '0) req = 7'($urandom_range(1, 127));
      xfer($urandom, $urandom_range(0, 3), 1, 0, '0,
           ($urandom_range(0, 1) == 1) ? 7'($urandom) : '0);
    end
    req = '0;
    repeat (3) @(negedge clk);

    // reset in the middle of WAIT
    req = 7'b0000010;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gate_en === 1'b1) seen = 1;
    end
    chk("mid_sel_reached", 32'(seen), 32'd1);
    mux_y = 32'hDEADBEEF;
    @(negedge clk);
    chk("mid_wait_data", out_data, 32'hDEADBEEF);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'hF);
    chk("mid_rst_gate", 32'(gate_en), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    req = '0;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_ack", 32'(ack), 32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
